// File: rtl/sqn_sweep_ctrl_pkg.sv
// sqn_sweep_ctrl_pkg: shared FSM states, default widths and popcount for the sweep controller
package sqn_sweep_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_e;
    localparam int DEF_VEC_W = 7;
    localparam int DEF_RES_W = 3;
    localparam int DEF_CNT_W = 10;
    localparam int INC_W = 8;
    function automatic logic [INC_W-1:0] popcount(input logic [31:0] v);
        popcount = '0;
        for (int i = 0; i < 32; i++) popcount = popcount + INC_W'(v[i]);
    endfunction
endpackage

// File: rtl/sqn_sweep_ctrl_if.sv
// sqn_sweep_ctrl_if: sweep control/stimulus/activity bundle
// master drives start, abort, gray_mode, res_i; slave (the controller) drives vec_o, busy, done, in_tog, out_tog
interface sqn_sweep_ctrl_if import sqn_sweep_ctrl_pkg::*; #(
    parameter int VEC_W = DEF_VEC_W,
    parameter int RES_W = DEF_RES_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic                   start;
    logic                   abort;
    logic                   gray_mode;
    logic [VEC_W-1:0]       vec_o;
    logic [RES_W-1:0]       res_i;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       in_tog;
    logic [RES_W*CNT_W-1:0] out_tog;
    modport master (output start, abort, gray_mode, res_i, input vec_o, busy, done, in_tog, out_tog);
    modport slave (input start, abort, gray_mode, res_i, output vec_o, busy, done, in_tog, out_tog);
endinterface

// File: rtl/sqn_act_counter.sv
// sqn_act_counter: saturating activity accumulator
// ports: clk, rst_n, clr (zero the count), en (accumulate inc), inc, cnt (saturates at all-ones)
module sqn_act_counter import sqn_sweep_ctrl_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);
    localparam int W = CNT_W + INC_W;
    logic [W-1:0] sum;
    assign sum = W'(cnt) + W'(inc);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= (|sum[W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: rtl/sqn_sweep_ctrl.sv
// sqn_sweep_ctrl: exhaustive input sweep of a combinational block with toggle-activity counting
// ports: clk, rst_n (async, active low), bus (slave side: start/abort/gray_mode/res_i in; vec_o/busy/done/in_tog/out_tog out)
module sqn_sweep_ctrl import sqn_sweep_ctrl_pkg::*; #(
    parameter int VEC_W = DEF_VEC_W,
    parameter int RES_W = DEF_RES_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst_n,
    sqn_sweep_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;
    localparam logic [VEC_W-1:0] LAST = '1;
    logic [1:0]             state, nxt;
    logic [VEC_W-1:0]       idx, gvec;
    logic [RES_W-1:0]       prev_res;
    logic                   gm, clr, run_go, drain_go, smp, in_en, out_en;
    logic [INC_W-1:0]       in_inc;
    logic [CNT_W-1:0]       itog;
    logic [RES_W*CNT_W-1:0] otog;
    always_comb begin
        nxt = (state == IDLE)  ? ((bus.start && !bus.abort) ? RUN : IDLE) :
              (state == RUN)   ? (bus.abort ? IDLE : (idx == LAST ? DRAIN : RUN)) :
              (state == DRAIN) ? (bus.abort ? IDLE : DONE) : IDLE;
    end
    assign clr      = (state == IDLE) && bus.start && !bus.abort;
    assign run_go   = (state == RUN) && !bus.abort;
    assign drain_go = (state == DRAIN) && !bus.abort;
    assign gvec     = gm ? (idx ^ (idx >> 1)) : idx;
    // res_i reflects the vector applied one cycle earlier, so sampling starts once idx has moved past 0
    assign smp      = (run_go && idx != '0) || drain_go;
    // the first vector and the first response have no predecessor and contribute no toggles
    assign in_en    = run_go && idx != '0;
    assign out_en   = smp && !(state == RUN && idx == VEC_W'(1));
    assign in_inc   = popcount(32'(gvec ^ bus.vec_o));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            gm        <= 1'b0;
            bus.vec_o <= '0;
            prev_res  <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state    <= nxt;
            bus.busy <= (nxt == RUN) || (nxt == DRAIN);
            bus.done <= nxt == DONE;
            if (clr) begin
                idx <= '0;
                gm  <= bus.gray_mode;
            end
            if (run_go) begin
                bus.vec_o <= gvec;
                idx       <= idx + VEC_W'(1);
            end
            if (smp) prev_res <= bus.res_i;
        end
    end
    sqn_act_counter #(.CNT_W(CNT_W)) u_in (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(in_en), .inc(in_inc), .cnt(itog)
    );
    for (genvar r = 0; r < RES_W; r++) begin : g_out
        sqn_act_counter #(.CNT_W(CNT_W)) u_out (
            .clk(clk), .rst_n(rst_n), .clr(clr), .en(out_en),
            .inc(INC_W'(bus.res_i[r] ^ prev_res[r])), .cnt(otog[r*CNT_W +: CNT_W])
        );
    end
    assign bus.in_tog  = itog;
    assign bus.out_tog = otog;
endmodule

// File: tb/tb_sqn_sweep_ctrl.sv
// tb_sqn_sweep_ctrl: table-driven, hand-sequenced and randomized checks of the sweep controller
module tb_sqn_sweep_ctrl;
    typedef struct {
        int g; int ab; int rs; int e_cyc; int e_in; int e_o2; int e_o1; int e_o0; int e_vec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic lut_on = 1'b0;
    logic [2:0] lut [128];
    int n_vec = 0;
    int n_bad = 0;
    int last_vec = 0;
    vec_t tbl [8];

    always #5 clk = ~clk;

    sqn_sweep_ctrl_if #(.VEC_W(7), .RES_W(3), .CNT_W(10)) bus ();
    sqn_sweep_ctrl_if #(.VEC_W(7), .RES_W(3), .CNT_W(6)) bus6 ();

    sqn_sweep_ctrl #(.VEC_W(7), .RES_W(3), .CNT_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    sqn_sweep_ctrl #(.VEC_W(7), .RES_W(3), .CNT_W(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

    assign bus.res_i  = lut_on ? lut[bus.vec_o] : bus.vec_o[2:0];
    assign bus6.res_i = bus6.vec_o[2:0];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int gc(input int g, input int k);
        return (g != 0) ? (k ^ (k >> 1)) : k;
    endfunction

    function automatic logic [2:0] resp(input int v);
        logic [6:0] a;
        a = 7'(v);
        return lut_on ? lut[a] : a[2:0];
    endfunction

    function automatic int sat(input int x);
        return (x > 1023) ? 1023 : x;
    endfunction

    // Reference: list the vectors a sweep applies and the responses it samples, then count bit changes
    function automatic vec_t model(input int g, input int ab);
        vec_t e;
        int na, ns;
        logic [2:0] r, pr;
        e = '{g, ab, 0, (ab == 0) ? 130 : 0, 0, 0, 0, 0, 0};
        na = (ab == 0) ? 128 : ab - 1;
        ns = (ab == 0) ? 128 : ((ab >= 2) ? ab - 2 : 0);
        for (int k = 1; k < na; k++) e.e_in += $countones(gc(g, k) ^ gc(g, k - 1));
        for (int k = 1; k < ns; k++) begin
            r  = resp(gc(g, k));
            pr = resp(gc(g, k - 1));
            e.e_o0 += int'(r[0] ^ pr[0]);
            e.e_o1 += int'(r[1] ^ pr[1]);
            e.e_o2 += int'(r[2] ^ pr[2]);
        end
        e.e_in = sat(e.e_in);
        e.e_o0 = sat(e.e_o0);
        e.e_o1 = sat(e.e_o1);
        e.e_o2 = sat(e.e_o2);
        e.e_vec = (na > 0) ? gc(g, na - 1) : last_vec;
        return e;
    endfunction

    task automatic do_entry(input vec_t e);
        int cyc, dcyc, dn, both, bsy;
        dcyc = 0; dn = 0; both = 0; bsy = -1;
        @(negedge clk);
        bus.gray_mode = e.g[0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.gray_mode = ~e.g[0];
        cyc = 1;
        while (cyc < 140) begin
            bus.abort = (cyc == e.ab);
            bus.start = (cyc == e.rs);
            @(negedge clk);
            cyc++;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (bus.done) begin
                dn++;
                if (dcyc == 0) dcyc = cyc;
            end
            if (bus.done && bus.busy) both = 1;
            if (cyc == ((e.ab > 0) ? e.ab + 1 : 5)) bsy = int'(bus.busy);
        end
        chk("done_cycle", dcyc, e.e_cyc);
        chk("done_count", dn, (e.e_cyc != 0) ? 1 : 0);
        chk("busy_probe", bsy, (e.ab > 0) ? 0 : 1);
        chk("busy_done_overlap", both, 0);
        chk("in_tog", int'(bus.in_tog), e.e_in);
        chk("out_tog2", int'(bus.out_tog[20 +: 10]), e.e_o2);
        chk("out_tog1", int'(bus.out_tog[10 +: 10]), e.e_o1);
        chk("out_tog0", int'(bus.out_tog[0 +: 10]), e.e_o0);
        chk("vec_o", int'(bus.vec_o), e.e_vec);
        last_vec = e.e_vec;
    endtask

    initial begin
        int mx, g, ab;
        tbl[0] = '{0, 0,   0,  130, 247, 31, 63, 127, 127};
        tbl[1] = '{1, 0,   0,  130, 127, 16, 32, 64,  64};
        tbl[2] = '{0, 2,   0,  0,   0,   0,  0,  0,   0};
        tbl[3] = '{0, 10,  0,  0,   15,  1,  3,  7,   8};
        tbl[4] = '{1, 10,  0,  0,   8,   1,  2,  4,   12};
        tbl[5] = '{0, 0,   50, 130, 247, 31, 63, 127, 127};
        tbl[6] = '{1, 129, 0,  0,   127, 16, 32, 63,  64};
        tbl[7] = '{0, 129, 0,  0,   247, 31, 63, 126, 127};
        bus.start = 1'b0; bus.abort = 1'b0; bus.gray_mode = 1'b0;
        bus6.start = 1'b0; bus6.abort = 1'b0; bus6.gray_mode = 1'b0;
        for (int i = 0; i < 128; i++) lut[i] = 3'(i);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vec_o", int'(bus.vec_o), 0);
        chk("rst_in_tog", int'(bus.in_tog), 0);
        chk("rst_out_tog", int'(bus.out_tog), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);

        for (int i = 0; i < 8; i++) do_entry(tbl[i]);

        // simultaneous start+abort in IDLE must leave the controller idle with everything held
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        mx = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy || bus.done) mx = 1;
        end
        chk("sa_idle_active", mx, 0);
        chk("sa_in_tog_hold", int'(bus.in_tog), 247);
        chk("sa_out_tog0_hold", int'(bus.out_tog[0 +: 10]), 126);
        chk("sa_vec_hold", int'(bus.vec_o), 127);

        // reset pulse mid-RUN clears outputs without a clock edge; next sweep is a fresh one
        @(negedge clk);
        bus.gray_mode = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vec_o", int'(bus.vec_o), 0);
        chk("mid_rst_in_tog", int'(bus.in_tog), 0);
        chk("mid_rst_out_tog", int'(bus.out_tog), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_vec = 0;
        do_entry(tbl[0]);

        // narrow counters saturate instead of wrapping
        @(negedge clk);
        bus6.start = 1'b1;
        @(negedge clk);
        bus6.start = 1'b0;
        repeat (135) @(negedge clk);
        chk("sat6_out_tog0", int'(bus6.out_tog[0 +: 6]), 63);
        chk("sat6_out_tog1", int'(bus6.out_tog[6 +: 6]), 63);
        chk("sat6_out_tog2", int'(bus6.out_tog[12 +: 6]), 31);
        chk("sat6_in_tog", int'(bus6.in_tog), 63);

        // randomized response tables, orders and abort points against the reference
        lut_on = 1'b1;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 128; i++) lut[i] = 3'($urandom);
            g = int'($urandom_range(0, 1));
            ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 129));
            do_entry(model(g, ab));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sqn_sweep_ctrl.md
SQN_SWEEP_CTRL -- requirements
Module: sqn_sweep_ctrl

Interface
REQ-001 SHALL have parameter VEC_W, default 7, the input-vector width of the swept combinational block.
REQ-002 SHALL have parameter RES_W, default 3, the output width of the swept combinational block.
REQ-003 SHALL have parameter CNT_W, default 10, the width of every activity counter.
REQ-004 SHALL use a single clock and an asynchronous active-low reset, both listed first:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 Remaining ports:
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  one-cycle request to terminate the sweep in progress.
- gray_mode  in  1  sampled at start; 1 = Gray-code order, 0 = binary order.
- vec_o  out  VEC_W  registered stimulus to the swept block.
- res_i  in  RES_W  combinational response of the swept block to vec_o.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when a sweep completes.
- in_tog  out  CNT_W  total input-bit toggles applied.
- out_tog  out  RES_W*CNT_W  per-output toggle counts; bit i's count occupies slice [i*CNT_W +: CNT_W].

Function
REQ-006 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE -> RUN on start with abort low; in that cycle, clear all counters, clear idx to 0, and latch gray_mode.
REQ-008 In RUN, drive vec_o each cycle as follows, then increment idx:
- binary order: vec_o = idx.
- Gray order: vec_o = idx ^ (idx >> 1).
REQ-009 RUN -> DRAIN when idx = 2^VEC_W-1 is issued; RUN SHALL last exactly 2^VEC_W cycles.
REQ-010 Response latency is 1 cycle: sample res_i in the cycle after vec_o updates; DRAIN samples the final response.
REQ-011 DRAIN -> DONE after 1 cycle; DONE asserts done for 1 cycle, then -> IDLE.
REQ-012 Toggle counting starts with the second sampled vector and skips the first:
- each sample adds popcount(res_i ^ prev_res) into the per-bit out_tog counters.
- each applied vector adds popcount(vec_o ^ prev_vec) into in_tog.
REQ-013 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 start while busy SHALL be ignored.
REQ-015 abort in RUN or DRAIN SHALL return to IDLE next cycle; done stays low, counters hold partial values, vec_o holds.
REQ-016 start and abort in the same IDLE cycle: abort wins; remain in IDLE.
REQ-017 In IDLE and DONE, vec_o and all counters SHALL hold their values.
REQ-018 busy and done SHALL be registered and never high together.

Reset
REQ-019 While rst_n is low, regardless of clk:
- state = IDLE.
- vec_o = 0, idx = 0, prev registers = 0.
- in_tog = 0, out_tog = 0.
- busy = 0, done = 0.
REQ-020 Reset mid-sweep SHALL abandon the sweep with no done pulse; the first post-reset sweep behaves as a fresh one.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, default widths, and a popcount function.
REQ-022 One sub-module, sqn_act_counter, SHALL be instantiated RES_W+1 times, one per counter:
- saturating accumulate with a clear input.
- serves the out_tog bits and in_tog.

Verification
REQ-023 Binary sweep, stub res_i = vec_o[2:0]:
- expect out_tog = {31, 63, 127} for bits 2..0.
- expect in_tog = 247.
- expect done exactly 130 cycles after start.
REQ-024 Gray sweep, same stub:
- expect out_tog = {16, 32, 64}.
- expect in_tog = 127.
REQ-025 Abort 10 cycles into RUN:
- expect busy low on the next cycle and no done pulse.
- expect in_tog equal to the toggles applied before the abort.
REQ-026 start repulsed while busy, plus start+abort together in IDLE:
- expect the sweep length unchanged at 130 cycles.
- expect state to remain IDLE for the simultaneous case.
REQ-027 CNT_W = 6 binary sweep with stub res_i[0] = vec_o[0]:
- expect out_tog bit-0 count saturated at 63.
REQ-028 rst_n pulsed low mid-RUN:
- expect all outputs at 0 immediately.
- expect a following full sweep to match REQ-023.
